// File: rtl/dmem_access_unit_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dmem_access_unit_pkg : access sizes, FSM states, byte-lane helpers  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package dmem_access_unit_pkg;

  localparam int Strb_Bus = 8;

  localparam logic [1:0] Size_B = 2'd0;
  localparam logic [1:0] Size_H = 2'd1;
  localparam logic [1:0] Size_W = 2'd2;
  localparam logic [1:0] Size_D = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Byte-enable pattern of an access of the given size starting at lane 0.
  function automatic logic [Strb_Bus-1:0] size_mask(input logic [1:0] size);
    logic [Strb_Bus-1:0] m;
    case (size)
      Size_B:  m = 8'h01;
      Size_H:  m = 8'h03;
      Size_W:  m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_access_unit_lane_align.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dmem_lane_align : strobes, write/read lane shifting, misalign check |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module dmem_lane_align
  import dmem_access_unit_pkg::*;
(
  input  logic [2:0]          offset_i,
  input  logic [1:0]          size_i,
  input  logic                we_i,
  input  logic [63:0]         wdata_i,
  input  logic [63:0]         rdata_i,
  output logic                misalign_o,
  output logic [Strb_Bus-1:0] wstrb_o,
  output logic [63:0]         wdata_o,
  output logic [63:0]         rdata_o
);

  logic [Strb_Bus-1:0] w_size_mask;
  logic [Strb_Bus-1:0] w_strb;
  logic [2:0]          w_off_mask;
  logic [63:0]         w_wmask;
  logic [63:0]         w_rmask;

  assign w_size_mask = size_mask(size_i);
  assign w_strb      = w_size_mask << offset_i;

  always_comb begin
    w_off_mask = 3'b000;
    case (size_i)
      Size_B:  w_off_mask = 3'b000;
      Size_H:  w_off_mask = 3'b001;
      Size_W:  w_off_mask = 3'b011;
      default: w_off_mask = 3'b111;
    endcase
  end

  assign misalign_o = |(offset_i & w_off_mask);

  for (genvar i = 0; i < Strb_Bus; i++) begin : g_lane
    assign w_wmask[8*i +: 8] = {8{wstrb_o[i]}};
    assign w_rmask[8*i +: 8] = {8{w_size_mask[i]}};
  end

  assign wstrb_o = we_i ? w_strb : '0;
  assign wdata_o = (wdata_i << {offset_i, 3'b000}) & w_wmask;
  assign rdata_o = (rdata_i >> {offset_i, 3'b000}) & w_rmask;

endmodule
`default_nettype wire

// File: rtl/dmem_access_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dmem_access_unit : MEM-stage load/store to single-beat bus bridge   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module dmem_access_unit
  import dmem_access_unit_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_i,
  input  logic                we_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [2:0]          funct3_i,
  input  logic [DATA_W-1:0]   wdata_i,
  output logic                dcache_data_valid_o,
  output logic [DATA_W-1:0]   dcache_data_o,
  output logic                misalign_o,
  output logic                bus_err_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [Strb_Bus-1:0] mem_wstrb_o,
  input  logic                mem_ack_i,
  input  logic [DATA_W-1:0]   mem_rdata_i
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_e              state_q;
  logic [CNT_W-1:0]    wait_cnt_q;
  logic [DATA_W-1:0]   dcache_data_q;
  logic                misalign_q;
  logic                bus_err_q;
  logic                mem_req_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [Strb_Bus-1:0] mem_wstrb_q;

  logic                w_misalign;
  logic [Strb_Bus-1:0] w_wstrb;
  logic [DATA_W-1:0]   w_wdata;
  logic [DATA_W-1:0]   w_rdata;
  logic                w_unused;

  // Sign/zero extension is done in MEM, so the signedness bit is not needed.
  assign w_unused = funct3_i[2];

  // addr_i/funct3_i stay stable until valid, so the read path can use them at ack time.
  dmem_lane_align u_align (
    .offset_i   (addr_i[2:0]),
    .size_i     (funct3_i[1:0]),
    .we_i       (we_i),
    .wdata_i    (wdata_i),
    .rdata_i    (mem_rdata_i),
    .misalign_o (w_misalign),
    .wstrb_o    (w_wstrb),
    .wdata_o    (w_wdata),
    .rdata_o    (w_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      wait_cnt_q    <= '0;
      dcache_data_q <= '0;
      misalign_q    <= 1'b0;
      bus_err_q     <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_wstrb_q   <= '0;
    end else begin
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_i) begin
            if (w_misalign) begin
              misalign_q    <= 1'b1;
              dcache_data_q <= '0;
              state_q       <= DONE;
            end else begin
              mem_req_q   <= 1'b1;
              mem_we_q    <= we_i;
              mem_addr_q  <= {addr_i[ADDR_W-1:3], 3'b000};
              mem_wdata_q <= w_wdata;
              mem_wstrb_q <= w_wstrb;
              wait_cnt_q  <= '0;
              state_q     <= BUS;
            end
          end
        end
        BUS: begin
          if (mem_ack_i) begin
            mem_req_q     <= 1'b0;
            dcache_data_q <= mem_we_q ? '0 : w_rdata;
            state_q       <= DONE;
          end else if ((TIMEOUT != 0) && (wait_cnt_q == CNT_W'(TIMEOUT))) begin
            bus_err_q     <= 1'b1;
            mem_req_q     <= 1'b0;
            dcache_data_q <= '0;
            state_q       <= DONE;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dcache_data_valid_o = (state_q == IDLE) ? ~req_i : (state_q == DONE);
  assign dcache_data_o       = dcache_data_q;
  assign misalign_o          = misalign_q;
  assign bus_err_o           = bus_err_q;
  assign mem_req_o           = mem_req_q;
  assign mem_we_o            = mem_we_q;
  assign mem_addr_o          = mem_addr_q;
  assign mem_wdata_o         = mem_wdata_q;
  assign mem_wstrb_o         = mem_wstrb_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_access_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_dmem_access_unit : randomized bench with transaction-level model |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_dmem_access_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [63:0] addr_i = '0;
  logic [2:0]  funct3_i = '0;
  logic [63:0] wdata_i = '0;
  logic        dcache_data_valid_o;
  logic [63:0] dcache_data_o;
  logic        misalign_o;
  logic        bus_err_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [63:0] mem_addr_o;
  logic [63:0] mem_wdata_o;
  logic [7:0]  mem_wstrb_o;
  logic        mem_ack_i = 1'b0;
  logic [63:0] mem_rdata_i = '0;

  dmem_access_unit #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(TO)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .req_i               (req_i),
    .we_i                (we_i),
    .addr_i              (addr_i),
    .funct3_i            (funct3_i),
    .wdata_i             (wdata_i),
    .dcache_data_valid_o (dcache_data_valid_o),
    .dcache_data_o       (dcache_data_o),
    .misalign_o          (misalign_o),
    .bus_err_o           (bus_err_o),
    .mem_req_o           (mem_req_o),
    .mem_we_o            (mem_we_o),
    .mem_addr_o          (mem_addr_o),
    .mem_wdata_o         (mem_wdata_o),
    .mem_wstrb_o         (mem_wstrb_o),
    .mem_ack_i           (mem_ack_i),
    .mem_rdata_i         (mem_rdata_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle expectations written by the driver from the transaction model.
  bit          chk_en = 1'b0;
  logic        e_valid, e_req, e_mis, e_err, e_we;
  bit          c_bus = 1'b0, c_data = 1'b0;
  logic [63:0] e_addr, e_wdata, e_data;
  logic [7:0]  e_wstrb;

  logic [63:0] last_data, last_addr, last_wdata;
  logic [7:0]  last_wstrb;
  logic        last_we;
  int          req_rises = 0, mis_pulses = 0, err_pulses = 0;
  logic        prev_req = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid", dcache_data_valid_o, e_valid);
      chk("mem_req", mem_req_o, e_req);
      chk("misalign", misalign_o, e_mis);
      chk("bus_err", bus_err_o, e_err);
      if (c_bus) begin
        chk("mem_we", mem_we_o, e_we);
        chk("mem_addr", mem_addr_o, e_addr);
        chk("mem_wdata", mem_wdata_o, e_wdata);
        chk("mem_wstrb", mem_wstrb_o, e_wstrb);
        last_addr  <= mem_addr_o;
        last_wdata <= mem_wdata_o;
        last_wstrb <= mem_wstrb_o;
        last_we    <= mem_we_o;
      end
      if (c_data) begin
        chk("dcache_data", dcache_data_o, e_data);
        last_data <= dcache_data_o;
      end
      if (misalign_o) mis_pulses <= mis_pulses + 1;
      if (bus_err_o)  err_pulses <= err_pulses + 1;
    end
    if (mem_req_o && !prev_req) req_rises <= req_rises + 1;
    prev_req <= mem_req_o;
  end

  // ---------------- behavioural model ----------------
  function automatic logic m_mis(input logic [2:0] off, input logic [2:0] f3);
    int n = 1 << f3[1:0];
    return (int'(off) % n) != 0;
  endfunction

  function automatic logic [7:0] m_strb(input logic we, input logic [2:0] off, input logic [2:0] f3);
    logic [7:0] s = '0;
    int n = 1 << f3[1:0];
    for (int i = 0; i < 8; i++)
      if (we && i >= int'(off) && i < int'(off) + n) s[i] = 1'b1;
    return s;
  endfunction

  function automatic logic [63:0] m_wdata(input logic [63:0] wd, input logic we,
                                          input logic [2:0] off, input logic [2:0] f3);
    logic [63:0] r = '0;
    logic [7:0]  s = m_strb(we, off, f3);
    for (int i = 0; i < 8; i++)
      if (s[i]) r[8*i +: 8] = wd[8*(i - int'(off)) +: 8];
    return r;
  endfunction

  function automatic logic [63:0] m_rdata(input logic [63:0] rd, input logic [2:0] off,
                                          input logic [2:0] f3);
    logic [63:0] r = '0;
    int n = 1 << f3[1:0];
    for (int j = 0; j < n; j++)
      if (int'(off) + j < 8) r[8*j +: 8] = rd[8*(int'(off) + j) +: 8];
    return r;
  endfunction

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      req_i = 1'b0; we_i = 1'($urandom); addr_i = {$urandom, $urandom};
      funct3_i = 3'($urandom); mem_ack_i = 1'($urandom);
      mem_rdata_i = {$urandom, $urandom};
      e_valid = 1'b1; e_req = 1'b0; e_mis = 1'b0; e_err = 1'b0; c_bus = 1'b0; c_data = 1'b0;
      step();
    end
  endtask

  // d = BUS cycle index carrying the ack; d > TO means the ack never comes.
  task automatic do_txn(input logic we, input logic [63:0] addr, input logic [2:0] f3,
                        input logic [63:0] wd, input int d, input logic [63:0] rd);
    logic [2:0] off;
    logic       acked;
    off = addr[2:0];
    req_i = 1'b1; we_i = we; addr_i = addr; funct3_i = f3; wdata_i = wd;
    mem_ack_i = 1'($urandom); mem_rdata_i = {$urandom, $urandom};
    e_valid = 1'b0; e_req = 1'b0; e_mis = 1'b0; e_err = 1'b0; c_bus = 1'b0; c_data = 1'b0;
    step();
    if (m_mis(off, f3)) begin
      mem_ack_i = 1'($urandom); mem_rdata_i = {$urandom, $urandom};
      e_valid = 1'b1; e_mis = 1'b1; c_data = 1'b1; e_data = '0;
      step();
      return;
    end
    acked = 1'b0;
    for (int k = 0; k <= TO; k++) begin
      e_valid = 1'b0; e_req = 1'b1; c_bus = 1'b1; c_data = 1'b0;
      e_we = we; e_addr = {addr[63:3], 3'b000};
      e_wdata = m_wdata(wd, we, off, f3); e_wstrb = m_strb(we, off, f3);
      if (k == d) begin mem_ack_i = 1'b1; mem_rdata_i = rd; end
      else begin mem_ack_i = 1'b0; mem_rdata_i = {$urandom, $urandom}; end
      step();
      if (k == d) begin acked = 1'b1; break; end
    end
    mem_ack_i = 1'($urandom); mem_rdata_i = {$urandom, $urandom};
    c_bus = 1'b0; e_req = 1'b0; e_valid = 1'b1; e_err = !acked; c_data = 1'b1;
    e_data = (!acked || we) ? 64'h0 : m_rdata(rd, off, f3);
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          r0, m0, x0, sz, off;
    logic        we;
    logic [2:0]  f3;
    logic [63:0] a;

    #2;
    chk("rst_valid", dcache_data_valid_o, 1'b1);
    chk("rst_data", dcache_data_o, 64'h0);
    chk("rst_req", mem_req_o, 1'b0);
    chk("rst_we", mem_we_o, 1'b0);
    chk("rst_addr", mem_addr_o, 64'h0);
    chk("rst_wdata", mem_wdata_o, 64'h0);
    chk("rst_wstrb", mem_wstrb_o, 8'h0);
    chk("rst_mis", misalign_o, 1'b0);
    chk("rst_err", bus_err_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk_en = 1'b1;
    idle(2);

    do_txn(1'b0, 64'h1004, 3'd2, 64'h0, 0, 64'h89ABCDEF_01234567);
    chk("lw_data", last_data, 64'h0000_0000_89AB_CDEF);
    chk("lw_addr", last_addr, 64'h1000);
    idle(1);

    do_txn(1'b1, 64'h2003, 3'd0, 64'h1122_3344_5566_77AB, 4, 64'h0);
    chk("sb_wstrb", last_wstrb, 8'h08);
    chk("sb_wdata", last_wdata, 64'h0000_0000_AB00_0000);
    chk("sb_we", last_we, 1'b1);
    idle(1);

    r0 = req_rises; m0 = mis_pulses;
    do_txn(1'b0, 64'h3001, 3'd1, 64'h0, 0, 64'h0);
    chk("lh_mis_pulse", mis_pulses, m0 + 1);
    chk("lh_no_req", req_rises, r0);
    idle(1);

    x0 = err_pulses;
    do_txn(1'b0, 64'h4000, 3'd3, 64'h0, 99, 64'h0);
    chk("to_err_pulse", err_pulses, x0 + 1);
    chk("to_data", last_data, 64'h0);
    idle(1);

    r0 = req_rises;
    do_txn(1'b0, 64'h5008, 3'd3, 64'h0, 0, 64'hDEAD_BEEF_CAFE_F00D);
    do_txn(1'b1, 64'h5010, 3'd3, 64'h0123_4567_89AB_CDEF, 0, 64'h0);
    chk("b2b_req_count", req_rises, r0 + 2);
    chk("b2b_sd_wstrb", last_wstrb, 8'hFF);

    for (int t = 0; t < 300; t++) begin
      we = 1'($urandom);
      f3 = we ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 6));
      sz = 1 << f3[1:0];
      off = $urandom_range(0, 7);
      if ($urandom_range(0, 3) != 0) off = off - (off % sz);
      a = {$urandom, $urandom};
      a[2:0] = 3'(off);
      do_txn(we, a, f3, {$urandom, $urandom}, $urandom_range(0, 6), {$urandom, $urandom});
      idle($urandom_range(0, 2));
    end

    chk_en = 1'b0;
    req_i = 1'b1; we_i = 1'b0; addr_i = 64'h6000; funct3_i = 3'd3; mem_ack_i = 1'b0;
    step();
    step();
    chk("mid_bus_req", mem_req_o, 1'b1);
    #2;
    rst_n = 1'b0;
    req_i = 1'b0;
    #1;
    chk("arst_req", mem_req_o, 1'b0);
    chk("arst_addr", mem_addr_o, 64'h0);
    chk("arst_wstrb", mem_wstrb_o, 8'h0);
    chk("arst_data", dcache_data_o, 64'h0);
    chk("arst_valid", dcache_data_valid_o, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk_en = 1'b1;
    idle(2);
    do_txn(1'b0, 64'h7006, 3'd5, 64'h0, 1, 64'hA1B2_C3D4_E5F6_0718);
    chk("post_rst_lhu", last_data, 64'h0000_0000_0000_A1B2);
    idle(2);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
